// File: rtl/nv_ram_rwsp_160x16_fifo_ctrl_pkg.sv
// Shared sizing constants and pointer helpers for the 160x16 RAM-backed FIFO.
package nv_ram_rwsp_160x16_fifo_ctrl_pkg;

  localparam int unsigned DEPTH = 160;
  localparam int unsigned AW    = 8;
  localparam int unsigned DW    = 16;
  localparam int unsigned CW    = 8;

  // Depth is not a power of two, so pointers wrap explicitly at DEPTH-1.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr);
    return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
  endfunction

endpackage

// File: rtl/nv_ram_rwsp_160x16_fifo_ctrl_ram.sv
// 160x16 two-port RAM with a two-stage registered read: re latches the
// address, ore latches the addressed word into dout.
module nv_ram_rwsp_160x16 (
  input  logic        clk,
  input  logic [7:0]  ra,
  input  logic        re,
  input  logic        ore,
  output logic [15:0] dout,
  input  logic [7:0]  wa,
  input  logic        we,
  input  logic [15:0] di,
  input  logic [31:0] pwrbus_ram_pd
);

  logic [15:0] mem [0:159];
  logic [7:0]  ra_d;

  // Power-management bus has no effect in this behavioural array.
  logic unused_pwr;
  assign unused_pwr = ^pwrbus_ram_pd;

  always_ff @(posedge clk) begin
    if (we)  mem[wa] <= di;
    if (re)  ra_d    <= ra;
    if (ore) dout    <= mem[ra_d];
  end

endmodule

// File: rtl/nv_ram_rwsp_160x16_fifo_ctrl.sv
// Valid/ready FIFO controller sequencing the registered-read 160x16 RAM so
// that the RAM dout register is the read-side output stage.
module nv_ram_rwsp_160x16_fifo_ctrl
  import nv_ram_rwsp_160x16_fifo_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_pvld,
  output logic          wr_prdy,
  input  logic [DW-1:0] wr_pd,
  output logic          rd_pvld,
  input  logic          rd_prdy,
  output logic [DW-1:0] rd_pd,
  input  logic          flush,
  output logic [CW-1:0] occupancy,
  input  logic [31:0]   pwrbus_ram_pd
);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] occ_q, occ_d;
  logic          s1_vld_q, s1_vld_d;
  logic          s2_vld_q, s2_vld_d;

  logic          push;
  logic          pop;
  logic          re;
  logic          ore;
  logic [CW-1:0] unread;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      s1_vld_q <= s1_vld_d;
      s2_vld_q <= s2_vld_d;
    end
  end

  // Entries stay counted until popped, so a slot in flight is never rewritten.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    s1_vld_d = s1_vld_q;
    s2_vld_d = s2_vld_q;

    wr_prdy = (occ_q < CW'(DEPTH)) & ~flush;
    push    = wr_pvld & wr_prdy;
    pop     = s2_vld_q & rd_prdy;
    unread  = occ_q - CW'(s1_vld_q) - CW'(s2_vld_q);
    ore     = s1_vld_q & (~s2_vld_q | rd_prdy);
    re      = (unread != '0) & (~s1_vld_q | ore) & ~flush;

    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (re)   rd_ptr_d = ptr_inc(rd_ptr_q);
    s1_vld_d = re | (s1_vld_q & ~ore);
    s2_vld_d = ore | (s2_vld_q & ~rd_prdy);
    occ_d    = occ_q + CW'(push) - CW'(pop);

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
      s1_vld_d = 1'b0;
      s2_vld_d = 1'b0;
    end
  end

  assign rd_pvld   = s2_vld_q;
  assign occupancy = occ_q;

  nv_ram_rwsp_160x16 u_ram (
    .clk           (clk),
    .ra            (rd_ptr_q),
    .re            (re),
    .ore           (ore),
    .dout          (rd_pd),
    .wa            (wr_ptr_q),
    .we            (push),
    .di            (wr_pd),
    .pwrbus_ram_pd (pwrbus_ram_pd)
  );

endmodule

// File: tb/tb_nv_ram_rwsp_160x16_fifo_ctrl.sv
// Self-checking bench: queue-based FIFO model checked every cycle plus
// directed latency, backpressure, flush and reset scenarios.
module tb_nv_ram_rwsp_160x16_fifo_ctrl;
  import nv_ram_rwsp_160x16_fifo_ctrl_pkg::*;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_pvld = 1'b0;
  logic          wr_prdy;
  logic [DW-1:0] wr_pd = '0;
  logic          rd_pvld;
  logic          rd_prdy = 1'b0;
  logic [DW-1:0] rd_pd;
  logic          flush = 1'b0;
  logic [CW-1:0] occupancy;
  logic [31:0]   pwrbus_ram_pd = '0;

  int            n_chk = 0;
  int            n_fail = 0;
  int            cyc = 0;
  int            pop_cnt = 0;
  int            last_pop_cyc = 0;
  logic [DW-1:0] last_pop_data = '0;
  logic [DW-1:0] model_q[$];
  logic          t4_done = 1'b0;

  nv_ram_rwsp_160x16_fifo_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .wr_pvld       (wr_pvld),
    .wr_prdy       (wr_prdy),
    .wr_pd         (wr_pd),
    .rd_pvld       (rd_pvld),
    .rd_prdy       (rd_prdy),
    .rd_pd         (rd_pd),
    .flush         (flush),
    .occupancy     (occupancy),
    .pwrbus_ram_pd (pwrbus_ram_pd)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: the FIFO contents as a queue; occupancy is its size, head is rd_pd.
  initial begin
    logic          prev_stall;
    logic [DW-1:0] prev_pd;
    int            sz;
    prev_stall = 1'b0;
    prev_pd    = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        model_q.delete();
        prev_stall = 1'b0;
      end else begin
        sz = model_q.size();
        chk("occupancy", 32'(occupancy), 32'(sz));
        chk("wr_prdy", 32'(wr_prdy), 32'((sz < DEPTH) && !flush));
        if (sz == 0) chk("rd_pvld_empty", 32'(rd_pvld), 0);
        else if (rd_pvld) chk("rd_pd", 32'(rd_pd), 32'(model_q[0]));
        if (prev_stall) begin
          chk("stall_pvld", 32'(rd_pvld), 1);
          chk("stall_pd", 32'(rd_pd), 32'(prev_pd));
        end
        if (dut.push && dut.re)
          chk("rw_same_addr", 32'(dut.wr_ptr_q == dut.rd_ptr_q), 0);
        prev_stall = rd_pvld && !rd_prdy && !flush;
        prev_pd    = rd_pd;
        if (flush) begin
          model_q.delete();
        end else begin
          if (rd_pvld && rd_prdy && sz > 0) begin
            last_pop_data = model_q.pop_front();
            last_pop_cyc  = cyc;
            pop_cnt++;
          end
          if (wr_pvld && sz < DEPTH) model_q.push_back(wr_pd);
        end
      end
    end
  end

  // Called and returns at posedge+1; pushes base, base+1, ... until n accepted.
  task automatic push_words(input int base, input int n, input int budget);
    int idx;
    int used;
    idx = 0;
    used = 0;
    wr_pvld = 1'b1;
    wr_pd = DW'(base);
    while (idx < n && used < budget) begin
      @(negedge clk);
      if (wr_prdy) idx++;
      @(posedge clk);
      #1;
      used++;
      if (idx < n) wr_pd = DW'(base + idx);
      else wr_pvld = 1'b0;
    end
    wr_pvld = 1'b0;
    chk("push_words_done", 32'(idx), 32'(n));
  endtask

  task automatic wait_pops(input int target, input int budget);
    int used;
    used = 0;
    while (pop_cnt < target && used < budget) begin
      @(posedge clk);
      #1;
      used++;
    end
    chk("wait_pops_done", 32'(pop_cnt >= target), 1);
  endtask

  initial begin
    int base;
    int c0;

    rst = 1'b1;
    #1;
    chk("rst_wr_prdy", 32'(wr_prdy), 1);
    chk("rst_rd_pvld", 32'(rd_pvld), 0);
    chk("rst_occupancy", 32'(occupancy), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single word first-word latency.
    @(posedge clk); #1;
    wr_pvld = 1'b1; wr_pd = 16'hA5A5; rd_prdy = 1'b1;
    @(posedge clk); #1 wr_pvld = 1'b0;
    #2;
    chk("t1_c1_occ", 32'(occupancy), 1);
    chk("t1_c1_pvld", 32'(rd_pvld), 0);
    @(posedge clk); #3;
    chk("t1_c2_pvld", 32'(rd_pvld), 0);
    @(posedge clk); #3;
    chk("t1_c3_pvld", 32'(rd_pvld), 1);
    chk("t1_c3_pd", 32'(rd_pd), 32'h0000A5A5);
    @(posedge clk); #3;
    chk("t1_c4_occ", 32'(occupancy), 0);
    chk("t1_c4_pvld", 32'(rd_pvld), 0);

    // Streaming 320 words: one per cycle after a 3-cycle fill.
    @(posedge clk); #1;
    base = pop_cnt;
    c0 = cyc;
    push_words(0, 320, 400);
    wait_pops(base + 320, 20);
    chk("t2_pops", 32'(pop_cnt - base), 320);
    chk("t2_last_pop_cycle", 32'(last_pop_cyc - c0), 322);
    chk("t2_last_data", 32'(last_pop_data), 319);

    // Fill to full under backpressure, then a single pop reopens wr_prdy.
    rd_prdy = 1'b0;
    base = pop_cnt;
    push_words(1000, 160, 200);
    wr_pvld = 1'b1; wr_pd = DW'(1160);
    repeat (4) begin
      #2;
      chk("t3_full_occ", 32'(occupancy), 160);
      chk("t3_full_prdy", 32'(wr_prdy), 0);
      @(posedge clk); #1;
    end
    rd_prdy = 1'b1;
    #2;
    chk("t3_pop_cycle_prdy", 32'(wr_prdy), 0);
    chk("t3_pop_cycle_pvld", 32'(rd_pvld), 1);
    @(posedge clk); #1 rd_prdy = 1'b0;
    #2;
    chk("t3_after_pop_prdy", 32'(wr_prdy), 1);
    chk("t3_after_pop_occ", 32'(occupancy), 159);
    @(posedge clk); #1 wr_pvld = 1'b0;
    #2;
    chk("t3_refill_occ", 32'(occupancy), 160);
    @(posedge clk); #1 rd_prdy = 1'b1;
    wait_pops(base + 161, 250);
    chk("t3_last_data", 32'(last_pop_data), 1160);

    // 1000 words against a 30% duty-cycle reader.
    base = pop_cnt;
    t4_done = 1'b0;
    fork
      begin
        push_words(2000, 1000, 8000);
        t4_done = 1'b1;
      end
      begin
        int n;
        n = 0;
        while ((!t4_done || occupancy != '0) && n < 10000) begin
          rd_prdy = ($urandom_range(0, 9) < 3);
          @(posedge clk); #1;
          n++;
        end
      end
    join
    rd_prdy = 1'b1;
    wait_pops(base + 1000, 50);
    chk("t4_pops", 32'(pop_cnt - base), 1000);
    chk("t4_last_data", 32'(last_pop_data), 2999);

    // Flush with 50 entries held.
    rd_prdy = 1'b0;
    push_words(3000, 50, 100);
    repeat (3) @(posedge clk);
    #1;
    flush = 1'b1; rd_prdy = 1'b1;
    #2;
    chk("t5_flush_prdy", 32'(wr_prdy), 0);
    @(posedge clk); #1 flush = 1'b0;
    #2;
    chk("t5_post_occ", 32'(occupancy), 0);
    chk("t5_post_pvld", 32'(rd_pvld), 0);
    @(posedge clk); #1;
    base = pop_cnt;
    push_words(32'h1234, 1, 5);
    wait_pops(base + 1, 10);
    chk("t5_readback", 32'(last_pop_data), 32'h1234);

    // Asynchronous reset mid-stream at occupancy 77.
    rd_prdy = 1'b0;
    push_words(4000, 77, 100);
    rd_prdy = 1'b1; wr_pvld = 1'b1; wr_pd = DW'(4077);
    #1;
    chk("t6_pre_occ", 32'(occupancy), 77);
    chk("t6_pre_pvld", 32'(rd_pvld), 1);
    rst = 1'b1;
    #1;
    chk("t6_rst_occ", 32'(occupancy), 0);
    chk("t6_rst_pvld", 32'(rd_pvld), 0);
    chk("t6_rst_prdy", 32'(wr_prdy), 1);
    wr_pvld = 1'b0; rd_prdy = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    base = pop_cnt;
    rd_prdy = 1'b1;
    push_words(32'h5A5A, 1, 5);
    wait_pops(base + 1, 10);
    chk("t6_readback", 32'(last_pop_data), 32'h5A5A);
    @(posedge clk); #3;
    chk("t6_final_occ", 32'(occupancy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/nv_ram_rwsp_160x16_fifo_ctrl.md
Name: nv_ram_rwsp_160x16_fifo_ctrl

Overview:
- Valid/ready FIFO built around the 160x16 registered-read two-port RAM (nv_ram_rwsp_160x16).
- Sequences the RAM's two-stage read pipeline: re latches the read address, ore latches the data.
- Provides full one-word-per-cycle throughput under backpressure without corrupting in-flight data.
- Used as the standard 160-entry elastic buffer between NVDLA datapath stages.

Parameters:
DEPTH, 160, number of entries; must equal the RAM word count; need not be a power of two.
AW, 8, RAM address and pointer width.
DW, 16, data width.
CW, 8, occupancy counter width; must hold the value DEPTH.

Ports:
clk  in  1  core clock; all logic is rising-edge.
rst  in  1  asynchronous, active-high reset.
wr_pvld  in  1  write data valid.
wr_prdy  out  1  write ready; push occurs when wr_pvld and wr_prdy are both high.
wr_pd  in  DW  write data.
rd_pvld  out  1  read data valid.
rd_prdy  in  1  read ready; pop occurs when rd_pvld and rd_prdy are both high.
rd_pd  out  DW  read data; it is the RAM's dout register.
flush  in  1  synchronous clear of the FIFO contents.
occupancy  out  CW  entries held, counting in-flight and output entries.
pwrbus_ram_pd  in  32  passed unchanged to the RAM.

Behaviour:
Reset values:
- wr_ptr, rd_ptr, occupancy, s1_vld and s2_vld are all 0.
- wr_prdy is 1 and rd_pvld is 0.
- rd_pd is unspecified until the first pop.

Write side:
- wr_prdy = (occupancy < DEPTH) & !flush. It uses the registered count, so a same-cycle pop does not open wr_prdy.
- On push: ram_we=1, ram_wa=wr_ptr, ram_di=wr_pd.
- wr_ptr increments and wraps from DEPTH-1 (159) to 0.

Read issue:
- unread = occupancy - s1_vld - s2_vld, computed from registered values.
- ore = s1_vld & (!s2_vld | rd_prdy).
- re = (unread != 0) & (!s1_vld | ore) & !flush, with ra = rd_ptr.
- On re, rd_ptr increments and wraps at DEPTH-1.

Pipeline valids:
- s1_vld' = re | (s1_vld & !ore).
- s2_vld' = ore | (s2_vld & !rd_prdy).
- rd_pvld = s2_vld.

Occupancy:
- occupancy' = occupancy + push - pop. Simultaneous push and pop leave it unchanged.
- An entry is freed only on pop, so its RAM slot cannot be overwritten while the entry is in flight. This keeps dout_ram stable while ore is stalled.

Latency and throughput:
- A push in cycle 0 on an empty FIFO gives re in cycle 1, ore in cycle 2, and rd_pvld=1 in cycle 3. First-word latency is 3 cycles.
- Steady-state throughput is 1 word per cycle with rd_prdy held high.

Backpressure:
- rd_pd and rd_pvld hold while rd_prdy is low.
- s1 holds its address; re is not reissued, so ra_d is unchanged.

Flush:
- Next cycle: pointers, occupancy, s1_vld and s2_vld are 0, and rd_pvld is 0.
- During the flush cycle: no push (wr_prdy=0), no re, and any pop is discarded.

Full and empty:
- At occupancy = DEPTH, wr_prdy=0.
- With occupancy = 0, re and rd_pvld are 0 and rd_prdy is ignored.

Reset mid-operation:
- All state clears asynchronously.
- RAM contents are retained but unreachable.

Illegal use:
- A RAM read and write to the same address in one cycle cannot occur by construction; the bench asserts this.

Decomposition:
- Shared package: DEPTH, AW, DW and CW constants, plus a pointer-increment-with-wrap function for non-power-of-two depths.
- Sub-module: instantiate nv_ram_rwsp_160x16 unchanged.
- The controller logic stays flat in this module.

Test Plan:
1. Empty FIFO, push 0xA5A5 in cycle 0, rd_prdy=1 -> rd_pvld=1 in cycle 3 with rd_pd=0xA5A5; occupancy goes 1 then 0 after the pop.
2. Stream 320 words (0..319), both sides always ready -> 1 word/cycle after the 3-cycle fill, data in order, pointers wrap 159->0 twice.
3. Push 160 words with rd_prdy=0 -> wr_prdy=0 at occupancy=160; one pop -> wr_prdy=1 the following cycle; the 161st word is read out last.
4. Random rd_prdy at a 30% duty cycle over 1000 words -> no loss or duplication, rd_pd stable while stalled, no same-address read/write.
5. Fill 50 words, flush with rd_prdy=1 -> occupancy=0 and rd_pvld=0 next cycle; a subsequent push of 0x1234 reads back as 0x1234.
6. Assert rst during streaming at occupancy=77 -> outputs return to reset values immediately; normal operation resumes after release.
